can_read_channel_fsm: RTL

Parametrised, registered successor of the microcontroller-interface read channel. It accepts one read request at a time from the host bus front end, decodes the address against a parameter-defined readable map, and drives a one-hot register select. It then waits a bounded number of cycles for the register file's acknowledge and returns the data or an error response. It can also emit a read-to-clear strobe for the interrupt register. It sits between the host bus adapter and the CAN register file, inside the microcontroller interface.

---
 rtl/can_read_channel_fsm.sv | 100 ++++++++++
 1 files changed

// File: rtl/can_read_channel_fsm.sv
// rtl/can_read_channel_fsm.sv - CAN register-file read channel: decode, one-hot select, bounded ack wait, response
module can_read_channel_fsm #(
    parameter int                        ADDR_W     = 6,
    parameter int                        DATA_W     = 32,
    parameter logic [(2**ADDR_W)-1:0]    VALID_MASK = 64'h0000_0001_FFF0_01FF,
    parameter int                        TIMEOUT    = 15,
    parameter bit                        RC_EN      = 1'b1,
    parameter logic [ADDR_W-1:0]         RC_ADDR    = 6'h03
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_rd_req,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_busy,
    output logic [(2**ADDR_W)-1:0]   o_rd_sel,
    input  logic [DATA_W-1:0]        i_reg_r_data,
    input  logic                     i_ack,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_rd_err,
    output logic                     o_rd_clr
);
    localparam int SEL_W = 2**ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   cnt;

    // Outputs are set on the transition into the state that owns them,
    // so every port is a flop and nothing combinational reaches a pin.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            o_busy     <= 1'b0;
            o_rd_sel   <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
            o_rd_clr   <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
            o_rd_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rd_req) begin
                        addr   <= i_addr;
                        o_busy <= 1'b1;
                        if (VALID_MASK[i_addr]) begin
                            state    <= WAIT;
                            cnt      <= '0;
                            o_rd_sel <= SEL_W'(1) << i_addr;
                        end else begin
                            state      <= RESP;
                            o_rd_data  <= '0;
                            o_rd_valid <= 1'b1;
                            o_rd_err   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Acknowledge takes priority over the timeout on the last wait cycle.
                    if (i_ack) begin
                        state      <= RESP;
                        o_rd_sel   <= '0;
                        o_rd_data  <= i_reg_r_data;
                        o_rd_valid <= 1'b1;
                        o_rd_clr   <= RC_EN && (addr == RC_ADDR);
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        o_rd_sel   <= '0;
                        o_rd_data  <= '0;
                        o_rd_valid <= 1'b1;
                        o_rd_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    o_rd_sel <= '0;
                end
            endcase
        end
    end
endmodule
